// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed seven-segment bus: waits for the bus to settle,
// decodes each scanned digit back to BCD and publishes complete HH:MM:SS frames.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sel_seg,
  input  logic [6:0]  seg,
  output logic [23:0] time_out,
  output logic        frame_valid,
  output logic        digit_err,
  output logic        sel_err,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef struct packed {
    logic       sel_ok;
    logic [2:0] idx;
    logic       seg_ok;
    logic [3:0] bcd;
  } sample_t;

  logic [14:0]      bus, in_q;
  logic [3:0]       stab_cnt;
  logic             take;
  sample_t          smp;
  logic [5:0]       seen, seen_upd;
  logic [5:0][3:0]  shadow, shadow_upd;
  logic             frame_done;

  assign bus  = {sel_seg, seg};
  // One sample per stable window: only the edge that brings the count up to SETTLE.
  assign take = (bus == in_q) && (stab_cnt == SETTLE - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q     <= 15'h7FFF;
      stab_cnt <= '0;
    end else begin
      in_q <= bus;
      if (bus != in_q)
        stab_cnt <= '0;
      else if (stab_cnt != SETTLE)
        stab_cnt <= stab_cnt + 4'd1;
    end
  end

  always_comb begin
    smp = '0;
    case (sel_seg)
      8'b1111_1110: begin smp.sel_ok = 1'b1; smp.idx = 3'd0; end
      8'b1111_1101: begin smp.sel_ok = 1'b1; smp.idx = 3'd1; end
      8'b1111_1011: begin smp.sel_ok = 1'b1; smp.idx = 3'd2; end
      8'b1111_0111: begin smp.sel_ok = 1'b1; smp.idx = 3'd3; end
      8'b1110_1111: begin smp.sel_ok = 1'b1; smp.idx = 3'd4; end
      8'b1101_1111: begin smp.sel_ok = 1'b1; smp.idx = 3'd5; end
      default: ;
    endcase
    case (seg)
      7'b1000000: begin smp.seg_ok = 1'b1; smp.bcd = 4'd0; end
      7'b1111001: begin smp.seg_ok = 1'b1; smp.bcd = 4'd1; end
      7'b0100100: begin smp.seg_ok = 1'b1; smp.bcd = 4'd2; end
      7'b0110000: begin smp.seg_ok = 1'b1; smp.bcd = 4'd3; end
      7'b0011001: begin smp.seg_ok = 1'b1; smp.bcd = 4'd4; end
      7'b0010010: begin smp.seg_ok = 1'b1; smp.bcd = 4'd5; end
      7'b0000010: begin smp.seg_ok = 1'b1; smp.bcd = 4'd6; end
      7'b1111000: begin smp.seg_ok = 1'b1; smp.bcd = 4'd7; end
      7'b0000000: begin smp.seg_ok = 1'b1; smp.bcd = 4'd8; end
      7'b0010000: begin smp.seg_ok = 1'b1; smp.bcd = 4'd9; end
      default: ;
    endcase
  end

  // Frame state as it would look after this sample; only meaningful with a legal select.
  always_comb begin
    seen_upd   = seen;
    shadow_upd = shadow;
    if (smp.seg_ok) begin
      seen_upd[smp.idx]   = 1'b1;
      shadow_upd[smp.idx] = smp.bcd;
    end else begin
      seen_upd[smp.idx]   = 1'b0;
    end
    frame_done = take && smp.sel_ok && smp.seg_ok && (seen_upd == 6'h3F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      shadow      <= '0;
      time_out    <= '0;
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      sel_err     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      sel_err     <= 1'b0;
      if (take) begin
        if (!smp.sel_ok) begin
          sel_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (!smp.seg_ok) begin
          digit_err <= 1'b1;
          seen      <= seen_upd;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (frame_done) begin
          time_out    <= shadow_upd;
          shadow      <= shadow_upd;
          seen        <= '0;
          frame_valid <= 1'b1;
        end else begin
          seen   <= seen_upd;
          shadow <= shadow_upd;
        end
      end
    end
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive end of the multiplexed seven-segment display bus (active-low digit select, active-low segments) used by the clock/timer display path.
- Samples the scanned bus once it has settled, decodes each segment pattern back to BCD, and reassembles the 24-bit HH:MM:SS BCD time word.
- Publishes the time word only after a complete 6-digit frame has been captured.
- Used as a display loopback monitor and self-check in the timer subsystem.

Parameters:
- SETTLE_CYCLES, 4: consecutive clock edges the select and segment bus must be unchanged before one sample is taken (legal range 1..15).

Ports:
- clk  in  1  system clock; the display bus is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- sel_seg  in  8  digit select, active-low one-hot in bits [5:0]; bits [7:6] must be 1.
- seg  in  7  segment pattern, active-low, gfedcba.
- time_out  out  24  last complete frame in BCD, digit n at [4n+3:4n].
- frame_valid  out  1  one-cycle pulse when time_out is updated.
- digit_err  out  1  one-cycle pulse when a settled sample has an undecodable segment pattern.
- sel_err  out  1  one-cycle pulse when a settled sample has an illegal sel_seg.
- err_cnt  out  8  saturating count of digit_err plus sel_err events.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - Outputs: time_out=0, frame_valid=0, digit_err=0, sel_err=0, err_cnt=0.
  - Internal: seen[5:0]=0, shadow=0, stab_cnt=0, in_q=15'h7FFF.
- Settle tracking (every edge):
  - in_q <= {sel_seg,seg}.
  - If {sel_seg,seg} != in_q, stab_cnt <= 0; otherwise stab_cnt increments and saturates at SETTLE_CYCLES.
- Sample rule:
  - A sample is taken on the edge at which stab_cnt increments to SETTLE_CYCLES.
  - Exactly one sample per stable window. A value held indefinitely is never resampled.
  - A window shorter than SETTLE_CYCLES edges produces no sample and no error.
- Select decode (sample edge):
  - 8'b11111110 selects digit 0; 11111101 → 1; 11111011 → 2; 11110111 → 3; 11101111 → 4; 11011111 → 5.
  - Any other value: sel_err pulses, err_cnt increments, seg is ignored, and seen/shadow are unchanged.
- Segment decode (valid select only):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - Any other pattern, including blank 1111111: digit_err pulses, err_cnt increments, and seen[d] is cleared.
  - Valid pattern: shadow[d] <= bcd and seen[d] <= 1. A repeated digit overwrites shadow[d] without error.
- Frame completion:
  - Occurs on the sample edge where the resulting seen equals 6'b111111.
  - On that edge: time_out <= shadow including the digit just decoded, seen <= 0, and frame_valid is high for the following cycle only.
  - Latency is 0 cycles from the sixth valid sample edge to the registered outputs.
- Digit order is irrelevant; any arrival order completes a frame.
- The error pulses and frame_valid are registered outputs, each high for exactly one cycle. digit_err and sel_err are mutually exclusive.
- err_cnt saturates at 8'hFF with no wrap.
- Reset mid-frame discards the partial frame. time_out stays 0 until a full new frame is captured.

Test Plan:
- SETTLE_CYCLES=4, digits 0..5 driven with patterns for 6,5,4,3,2,1, each held 8 cycles → one frame_valid pulse one cycle after the digit-5 sample edge; time_out=24'h123456; err_cnt=0.
- Digit 0 held 3 cycles then changed to digit 1 held 8 cycles → only digit 1 sampled. A subsequent full scan still yields a correct frame and no error pulses.
- Digit 2 with seg=7'b1111111 held 8 cycles → digit_err pulses once, err_cnt=1, no frame_valid. A rescan with valid digit 2 completes the frame.
- sel_seg=8'b11111100 held 8 cycles → sel_err pulses once, err_cnt=1, seen unchanged.
- Digit 3 pattern held 100 cycles → exactly one sample and no further effect; 300 illegal-select windows → err_cnt=8'hFF.
- rst_n low for 1 cycle after 3 valid digits, then 6 valid digits for 23:59:58 → frame_valid only after the 6 post-reset digits; time_out=24'h235958 and 0 before that.
